// File: rtl/hilo_mdu_ctrl.sv
// hilo_mdu_ctrl: EX-stage multiply/divide sequencer
// owning the architectural HI/LO registers.
module hilo_mdu_ctrl #(
    parameter int unsigned MUL_LAT  = 2,
    parameter logic [31:0] HILO_RST = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        ex_stall,
    input  logic        req_valid,
    input  logic [5:0]  req_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        stallreq,
    output logic        busy,
    output logic [31:0] hi_rdata,
    output logic [31:0] lo_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    localparam logic [4:0] MUL_LAST = 5'(MUL_LAT - 1);

    state_t      state, state_nx;
    logic [4:0]  cnt;
    logic        op_sgn;
    logic [31:0] op_a, op_b;
    logic [31:0] quot, rem;
    logic [31:0] hi, lo;
    logic        stall_c;

    logic dec_mul, dec_div, dec_sgn, dec_mthi, dec_mtlo;

    always_comb begin
        dec_mul  = 1'b0;
        dec_div  = 1'b0;
        dec_sgn  = 1'b0;
        dec_mthi = 1'b0;
        dec_mtlo = 1'b0;
        priority case (1'b1)
            req_op[5]: begin dec_mul = 1'b1; dec_sgn = 1'b1; end
            req_op[4]: dec_mul = 1'b1;
            req_op[3]: begin dec_div = 1'b1; dec_sgn = 1'b1; end
            req_op[2]: dec_div = 1'b1;
            req_op[1]: dec_mthi = 1'b1;
            req_op[0]: dec_mtlo = 1'b1;
            default: ;
        endcase
    end

    logic start_mul, start_div;
    assign start_mul = req_valid & dec_mul;
    assign start_div = req_valid & dec_div;

    always_comb begin
        state_nx = state;
        stall_c  = 1'b0;
        if (flush) begin
            state_nx = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    stall_c = start_mul | start_div;
                    if (start_mul)
                        state_nx = S_MUL;
                    else if (start_div)
                        state_nx = S_DIV;
                end
                S_MUL: begin
                    stall_c = 1'b1;
                    if (cnt == MUL_LAST)
                        state_nx = S_DONE;
                end
                S_DIV: begin
                    stall_c = 1'b1;
                    if (cnt == 5'd31)
                        state_nx = S_DONE;
                end
                S_DONE: begin
                    if (!ex_stall)
                        state_nx = S_IDLE;
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // Low 64 bits of a 64x64 product are correct for both signednesses.
    logic [63:0] mul_a, mul_b, prod;
    assign mul_a = {{32{op_sgn & op_a[31]}}, op_a};
    assign mul_b = {{32{op_sgn & op_b[31]}}, op_b};
    assign prod  = mul_a * mul_b;

    logic [31:0] a_mag, dvs, rem_nx, quot_nx;
    logic [32:0] rem_sh, diff;
    logic        q_bit, neg_q, neg_r;

    assign a_mag   = (dec_sgn & src_a[31]) ? -src_a : src_a;
    assign dvs     = (op_sgn & op_b[31]) ? -op_b : op_b;
    assign rem_sh  = {rem, quot[31]};
    assign diff    = rem_sh - {1'b0, dvs};
    assign q_bit   = ~diff[32];
    assign rem_nx  = q_bit ? diff[31:0] : rem_sh[31:0];
    assign quot_nx = {quot[30:0], q_bit};
    assign neg_q   = op_sgn & (op_a[31] ^ op_b[31]);
    assign neg_r   = op_sgn & op_a[31];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            op_sgn <= 1'b0;
            op_a   <= '0;
            op_b   <= '0;
            quot   <= '0;
            rem    <= '0;
            hi     <= HILO_RST;
            lo     <= HILO_RST;
        end else begin
            state <= state_nx;
            if (flush) begin
                cnt <= '0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        cnt <= '0;
                        if (start_mul | start_div) begin
                            op_a   <= src_a;
                            op_b   <= src_b;
                            op_sgn <= dec_sgn;
                            quot   <= a_mag;
                            rem    <= '0;
                        end else if (req_valid & dec_mthi) begin
                            hi <= src_a;
                        end else if (req_valid & dec_mtlo) begin
                            lo <= src_a;
                        end
                    end
                    S_MUL: begin
                        cnt <= cnt + 5'd1;
                        if (cnt == MUL_LAST)
                            {hi, lo} <= prod;
                    end
                    S_DIV: begin
                        cnt  <= cnt + 5'd1;
                        quot <= quot_nx;
                        rem  <= rem_nx;
                        if (cnt == 5'd31) begin
                            // Zero divisor returns all-ones and the raw dividend.
                            if (op_b == '0) begin
                                hi <= op_a;
                                lo <= '1;
                            end else begin
                                hi <= neg_r ? -rem_nx : rem_nx;
                                lo <= neg_q ? -quot_nx : quot_nx;
                            end
                        end
                    end
                    default: cnt <= '0;
                endcase
            end
        end
    end

    assign stallreq = stall_c & rst;
    assign busy     = (state == S_MUL) | (state == S_DIV);
    assign hi_rdata = hi;
    assign lo_rdata = lo;

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// tb_hilo_mdu_ctrl: randomized and directed checks of the
// HI/LO multiply/divide controller against an arithmetic model.
module tb_hilo_mdu_ctrl;

    localparam int unsigned MUL_LAT  = 2;
    localparam logic [31:0] HILO_RST = 32'h0;

    localparam logic [5:0] OP_MULT  = 6'b100000;
    localparam logic [5:0] OP_MULTU = 6'b010000;
    localparam logic [5:0] OP_DIV   = 6'b001000;
    localparam logic [5:0] OP_DIVU  = 6'b000100;
    localparam logic [5:0] OP_MTHI  = 6'b000010;
    localparam logic [5:0] OP_MTLO  = 6'b000001;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        ex_stall;
    logic        req_valid;
    logic [5:0]  req_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        stallreq;
    logic        busy;
    logic [31:0] hi_rdata;
    logic [31:0] lo_rdata;

    hilo_mdu_ctrl #(
        .MUL_LAT (MUL_LAT),
        .HILO_RST(HILO_RST)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .ex_stall (ex_stall),
        .req_valid(req_valid),
        .req_op   (req_op),
        .src_a    (src_a),
        .src_b    (src_b),
        .stallreq (stallreq),
        .busy     (busy),
        .hi_rdata (hi_rdata),
        .lo_rdata (lo_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;
    logic [31:0] m_hi, m_lo;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] top_op(input logic [5:0] op);
        for (int i = 5; i >= 0; i--)
            if (op[i]) return 6'b1 << i;
        return 6'b0;
    endfunction

    // Returns {hi, lo} from plain arithmetic.
    function automatic logic [63:0] ref_res(input logic [5:0] t,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (t == OP_MULT) return 64'(sa * sb);
        if (t == OP_MULTU) begin
            p = {32'b0, a} * {32'b0, b};
            return p;
        end
        if (b == 32'b0) return {a, 32'hFFFFFFFF};
        if (t == OP_DIV) begin
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    task automatic issue(input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int hold,
                         input string tag);
        logic [5:0] t;
        int n, exp_n;
        t = top_op(op);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        src_a     = a;
        src_b     = b;
        #1;
        if (t[5] | t[4] | t[3] | t[2]) begin
            exp_n = (t[5] | t[4]) ? 1 + MUL_LAT : 33;
            n = 0;
            while (stallreq && n < 60) begin
                n++;
                @(negedge clk);
                #1;
            end
            {m_hi, m_lo} = ref_res(t, a, b);
            check({tag, "/stall"}, 64'(n), 64'(exp_n));
            check({tag, "/hi"}, 64'(hi_rdata), 64'(m_hi));
            check({tag, "/lo"}, 64'(lo_rdata), 64'(m_lo));
            check({tag, "/busy"}, 64'(busy), 64'd0);
            if (hold > 0) begin
                ex_stall = 1'b1;
                repeat (hold) begin
                    @(negedge clk);
                    #1;
                    check({tag, "/hold"}, 64'({stallreq, busy}), 64'd0);
                end
                ex_stall = 1'b0;
            end
            @(negedge clk);
            req_valid = 1'b0;
            #1;
            check({tag, "/post"},
                  {31'b0, stallreq | busy, hi_rdata ^ lo_rdata},
                  {32'b0, m_hi ^ m_lo});
        end else begin
            check({tag, "/mtstall"}, 64'(stallreq), 64'd0);
            if (t[1]) m_hi = a;
            if (t[0]) m_lo = a;
            @(negedge clk);
            req_valid = 1'b0;
            #1;
            check({tag, "/hilo"}, {hi_rdata, lo_rdata}, {m_hi, m_lo});
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  op;
        logic [31:0] a, b;
        int sel;
        vectors     = 0;
        miscompares = 0;
        rst       = 1'b0;
        flush     = 1'b0;
        ex_stall  = 1'b0;
        req_valid = 1'b0;
        req_op    = 6'b0;
        src_a     = 32'b0;
        src_b     = 32'b0;
        #12;
        check("rst/ctl", 64'({stallreq, busy}), 64'd0);
        check("rst/hilo", {hi_rdata, lo_rdata}, {HILO_RST, HILO_RST});
        m_hi = HILO_RST;
        m_lo = HILO_RST;
        @(negedge clk);
        rst = 1'b1;

        issue(OP_MULT, 32'hFFFFFFFD, 32'd5, 0, "mult_neg");
        issue(OP_DIVU, 32'd100, 32'd7, 0, "divu");
        issue(OP_MULTU, 32'hFFFFFFFF, 32'd2, 0, "multu");
        issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 0, "div_neg");
        issue(OP_DIV, 32'd5, 32'd0, 0, "div_zero");
        issue(OP_DIVU, 32'h80000005, 32'd0, 0, "divu_zero");
        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 0, "div_ovf");
        issue(OP_DIV, 32'd7, 32'hFFFFFFFE, 0, "div_negb");
        issue(OP_MULT, 32'd1234, 32'hFFFF0000, 3, "done_hold");
        issue(OP_MTHI, 32'h0000CAFE, 32'd0, 0, "mthi");
        issue(OP_MTLO, 32'h0000BEEF, 32'd0, 0, "mtlo");
        issue(6'b000000, 32'h11111111, 32'd0, 0, "noop");
        issue(6'b011011, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, "prio");

        issue(OP_MTHI, 32'h1234, 32'd0, 0, "fl_mthi");
        issue(OP_MTLO, 32'h1234, 32'd0, 0, "fl_mtlo");
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = OP_DIV;
        src_a     = 32'd1000;
        src_b     = 32'd3;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush/stall", 64'(stallreq), 64'd0);
        @(negedge clk);
        flush     = 1'b0;
        req_valid = 1'b0;
        #1;
        check("flush/ctl", 64'({stallreq, busy}), 64'd0);
        check("flush/hilo", {hi_rdata, lo_rdata}, {32'h1234, 32'h1234});
        req_op = OP_MTHI;
        src_a  = 32'hDEAD;
        req_valid = 1'b1;
        flush  = 1'b1;
        @(negedge clk);
        flush     = 1'b0;
        req_valid = 1'b0;
        #1;
        check("flush/mthi", 64'(hi_rdata), 64'h1234);

        @(negedge clk);
        req_valid = 1'b1;
        req_op    = OP_DIV;
        src_a     = 32'd999;
        src_b     = 32'd4;
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("arst/ctl", 64'({stallreq, busy}), 64'd0);
        check("arst/hilo", {hi_rdata, lo_rdata}, {HILO_RST, HILO_RST});
        m_hi = HILO_RST;
        m_lo = HILO_RST;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        issue(OP_MULT, 32'd7, 32'hFFFFFFF7, 0, "arst_mult");

        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 9);
            a   = $urandom;
            b   = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) b = 32'b0;
            case (sel)
                0, 1:    op = OP_MULT;
                2:       op = OP_MULTU;
                3, 4:    op = OP_DIV;
                5, 6:    op = OP_DIVU;
                7:       op = OP_MTHI;
                8:       op = OP_MTLO;
                default: op = 6'($urandom_range(0, 63));
            endcase
            issue(op, a, b, $urandom_range(0, 2), $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
